// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 scan sequencer.
//   SC_*          Set-2 prefix and receiver error byte values
//   seq_state_e   sequencer FSM states
//   key_evt_t     one decoded key event {code, ext, brk, rpt}
package ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_ERR0  = 8'h00;
  localparam logic [7:0] SC_ERRF  = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_POP,
    ST_DECODE,
    ST_EMIT
  } seq_state_e;

  // rpt: press of the key that is already held (typematic repeat)
  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       rpt;
  } key_evt_t;

endpackage

// File: rtl/ps2_scan_sequencer.sv
// ps2_scan_sequencer: pops bytes from the PS/2 receiver FIFO, folds E0/F0
// prefixes into single key events and tracks the held key.
//   clk, rst                 clock, synchronous active-high reset
//   rx_data/rx_ready         receiver FIFO head byte / non-empty
//   rx_overflow              receiver overflow flag (latched into ovf_err)
//   rx_nextdata_n            active-low one-cycle pop strobe
//   evt_valid/evt_ready      event handshake; evt_code/ext/break/repeat payload
//   key_held/held_code       currently held key {ext, code}
//   press_count              non-repeat presses, 8-bit wrap
//   ovf_err/ovf_clr          sticky overflow flag and its clear
module ps2_scan_sequencer
  import ps2_pkg::*;
#(
  parameter int REPEAT_FILTER  = 1,
  parameter int PREFIX_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  input  logic       rx_overflow,
  output logic       rx_nextdata_n,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic       evt_repeat,
  output logic       key_held,
  output logic [8:0] held_code,
  output logic [7:0] press_count,
  output logic       ovf_err,
  input  logic       ovf_clr
);

  localparam bit          TMO_EN  = (PREFIX_TIMEOUT != 0);
  localparam logic [19:0] TMO_LIM = PREFIX_TIMEOUT[19:0];

  seq_state_e  state_q;
  logic [7:0]  byte_q;
  logic        ext_pend_q, brk_pend_q;
  logic [19:0] tmo_q;
  key_evt_t    evt_q;
  logic        evt_valid_q, nextdata_n_q;
  logic        key_held_q;
  logic [8:0]  held_code_q;
  logic [7:0]  press_count_q;
  logic        ovf_err_q;

  logic [8:0]  cur_key_d;
  logic        is_rep_d;
  logic [19:0] tmo_inc_d;

  assign cur_key_d = {ext_pend_q, byte_q};
  // a make of the key already held is a typematic repeat
  assign is_rep_d  = !brk_pend_q && key_held_q && (cur_key_d == held_code_q);
  assign tmo_inc_d = tmo_q + 20'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      byte_q        <= '0;
      ext_pend_q    <= 1'b0;
      brk_pend_q    <= 1'b0;
      tmo_q         <= '0;
      evt_q         <= '0;
      evt_valid_q   <= 1'b0;
      nextdata_n_q  <= 1'b1;
      key_held_q    <= 1'b0;
      held_code_q   <= '0;
      press_count_q <= '0;
      ovf_err_q     <= 1'b0;
    end else begin
      // set has priority over clear
      if (rx_overflow)  ovf_err_q <= 1'b1;
      else if (ovf_clr) ovf_err_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (rx_ready) begin
            byte_q       <= rx_data;
            tmo_q        <= '0;
            nextdata_n_q <= 1'b0;
            state_q      <= ST_POP;
          end else if (TMO_EN && (ext_pend_q || brk_pend_q)) begin
            // a prefix left dangling too long is dropped
            if (tmo_inc_d == TMO_LIM) begin
              ext_pend_q <= 1'b0;
              brk_pend_q <= 1'b0;
              tmo_q      <= '0;
            end else begin
              tmo_q <= tmo_inc_d;
            end
          end
        end
        ST_POP: begin
          nextdata_n_q <= 1'b1;
          state_q      <= ST_DECODE;
        end
        ST_DECODE: begin
          state_q <= ST_IDLE;
          if (byte_q == SC_EXT) begin
            ext_pend_q <= 1'b1;
          end else if (byte_q == SC_BREAK) begin
            brk_pend_q <= 1'b1;
          end else if (byte_q == SC_ERR0 || byte_q == SC_ERRF) begin
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
          end else begin
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
            if (!(is_rep_d && REPEAT_FILTER != 0)) begin
              evt_q <= '{code: byte_q, ext: ext_pend_q, brk: brk_pend_q, rpt: is_rep_d};
              if (!brk_pend_q && !is_rep_d) begin
                key_held_q    <= 1'b1;
                held_code_q   <= cur_key_d;
                press_count_q <= press_count_q + 8'd1;
              end else if (brk_pend_q && cur_key_d == held_code_q) begin
                key_held_q <= 1'b0;
              end
              evt_valid_q <= 1'b1;
              state_q     <= ST_EMIT;
            end
          end
        end
        ST_EMIT: begin
          // no pops while the consumer stalls; the FIFO absorbs backpressure
          if (evt_ready) begin
            evt_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rx_nextdata_n = nextdata_n_q;
  assign evt_valid     = evt_valid_q;
  assign evt_code      = evt_q.code;
  assign evt_ext       = evt_q.ext;
  assign evt_break     = evt_q.brk;
  assign evt_repeat    = evt_q.rpt;
  assign key_held      = key_held_q;
  assign held_code     = held_code_q;
  assign press_count   = press_count_q;
  assign ovf_err       = ovf_err_q;

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// tb_ps2_scan_sequencer: two sequencers fed identical byte streams from
// behavioural FIFOs. u0: REPEAT_FILTER=1, PREFIX_TIMEOUT=10.
// u1: REPEAT_FILTER=0, PREFIX_TIMEOUT=0.
module tb_ps2_scan_sequencer;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       rpt;
  } ev_t;

  typedef struct {
    logic [7:0] b;
    bit         ev;
    bit         rpt;
    logic [7:0] code;
    bit         ext;
    bit         brk;
    bit         held;
    logic [8:0] hc;
    logic [7:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_overflow = 1'b0, ovf_clr = 1'b0, evt_ready = 1'b1;
  logic [7:0] rx_data [2];
  logic       rx_ready [2];
  logic       nd [2], ev [2], ext [2], brk [2], rpt [2], held [2], ovf [2];
  logic [7:0] code [2], cnt [2];
  logic [8:0] hc [2];

  logic [7:0] fq0[$], fq1[$];
  ev_t        cap0[$], cap1[$];
  int         pops [2];
  int         width_err = 0;
  logic       prev_nd [2];
  int         errors = 0, checks = 0;

  always #5 clk = ~clk;

  ps2_scan_sequencer #(.REPEAT_FILTER(1), .PREFIX_TIMEOUT(10)) u0 (
    .clk(clk), .rst(rst), .rx_data(rx_data[0]), .rx_ready(rx_ready[0]),
    .rx_overflow(rx_overflow), .rx_nextdata_n(nd[0]), .evt_valid(ev[0]),
    .evt_ready(evt_ready), .evt_code(code[0]), .evt_ext(ext[0]),
    .evt_break(brk[0]), .evt_repeat(rpt[0]), .key_held(held[0]),
    .held_code(hc[0]), .press_count(cnt[0]), .ovf_err(ovf[0]), .ovf_clr(ovf_clr));

  ps2_scan_sequencer #(.REPEAT_FILTER(0), .PREFIX_TIMEOUT(0)) u1 (
    .clk(clk), .rst(rst), .rx_data(rx_data[1]), .rx_ready(rx_ready[1]),
    .rx_overflow(rx_overflow), .rx_nextdata_n(nd[1]), .evt_valid(ev[1]),
    .evt_ready(evt_ready), .evt_code(code[1]), .evt_ext(ext[1]),
    .evt_break(brk[1]), .evt_repeat(rpt[1]), .key_held(held[1]),
    .held_code(hc[1]), .press_count(cnt[1]), .ovf_err(ovf[1]), .ovf_clr(ovf_clr));

  // FIFO model + pop-strobe and event monitor, mid-cycle
  initial begin
    pops[0] = 0; pops[1] = 0; prev_nd[0] = 1'b1; prev_nd[1] = 1'b1;
  end
  always @(negedge clk) begin
    if (nd[0] === 1'b0) begin
      if (fq0.size() > 0) void'(fq0.pop_front());
      pops[0]++;
      if (prev_nd[0] === 1'b0) width_err++;
    end
    if (nd[1] === 1'b0) begin
      if (fq1.size() > 0) void'(fq1.pop_front());
      pops[1]++;
      if (prev_nd[1] === 1'b0) width_err++;
    end
    prev_nd[0] = nd[0];
    prev_nd[1] = nd[1];
    rx_ready[0] = (fq0.size() > 0);
    rx_data[0]  = rx_ready[0] ? fq0[0] : 8'h00;
    rx_ready[1] = (fq1.size() > 0);
    rx_data[1]  = rx_ready[1] ? fq1[0] : 8'h00;
    if (ev[0] && evt_ready) cap0.push_back({code[0], ext[0], brk[0], rpt[0]});
    if (ev[1] && evt_ready) cap1.push_back({code[1], ext[1], brk[1], rpt[1]});
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fq0.push_back(b);
    fq1.push_back(b);
  endtask

  task automatic step(input logic [7:0] b);
    push(b);
    repeat (7) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fq0.delete(); fq1.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cap0.delete(); cap1.delete();
  endtask

  task automatic wait_valid(input int idx, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 30 && !ok; k++) begin
      @(posedge clk); #1;
      if (ev[idx]) ok = 1'b1;
    end
  endtask

  task automatic chk_reset_vals(input string nm, input int i);
    chk(nm, {nd[i], ev[i], code[i], ext[i], brk[i], rpt[i], held[i], hc[i], cnt[i], ovf[i]},
        32'h8000_0000);
  endtask

  function automatic vec_t mk(input logic [7:0] b, input bit e, input bit r,
                              input logic [7:0] c, input bit x, input bit k,
                              input bit h, input logic [8:0] hcode, input logic [7:0] n);
    vec_t v;
    v.b = b; v.ev = e; v.rpt = r; v.code = c; v.ext = x; v.brk = k;
    v.held = h; v.hc = hcode; v.cnt = n;
    return v;
  endfunction

  vec_t tbl [21];

  initial begin
    ev_t g;
    bit  ok, e0;
    int  p0, diffs;
    logic [13:0] snap;

    //          byte   ev rpt code  ext brk held hc      cnt
    tbl[0]  = mk(8'h1C, 1, 0, 8'h1C, 0, 0, 1, 9'h01C, 8'd1);
    tbl[1]  = mk(8'hF0, 0, 0, 8'h00, 0, 0, 1, 9'h01C, 8'd1);
    tbl[2]  = mk(8'h1C, 1, 0, 8'h1C, 0, 1, 0, 9'h01C, 8'd1);
    tbl[3]  = mk(8'hE0, 0, 0, 8'h00, 0, 0, 0, 9'h01C, 8'd1);
    tbl[4]  = mk(8'h75, 1, 0, 8'h75, 1, 0, 1, 9'h175, 8'd2);
    tbl[5]  = mk(8'hE0, 0, 0, 8'h00, 0, 0, 1, 9'h175, 8'd2);
    tbl[6]  = mk(8'hF0, 0, 0, 8'h00, 0, 0, 1, 9'h175, 8'd2);
    tbl[7]  = mk(8'h75, 1, 0, 8'h75, 1, 1, 0, 9'h175, 8'd2);
    tbl[8]  = mk(8'h1C, 1, 0, 8'h1C, 0, 0, 1, 9'h01C, 8'd3);
    tbl[9]  = mk(8'h1C, 1, 1, 8'h1C, 0, 0, 1, 9'h01C, 8'd3);
    tbl[10] = mk(8'h1C, 1, 1, 8'h1C, 0, 0, 1, 9'h01C, 8'd3);
    tbl[11] = mk(8'hF0, 0, 0, 8'h00, 0, 0, 1, 9'h01C, 8'd3);
    tbl[12] = mk(8'h1C, 1, 0, 8'h1C, 0, 1, 0, 9'h01C, 8'd3);
    tbl[13] = mk(8'hFF, 0, 0, 8'h00, 0, 0, 0, 9'h01C, 8'd3);
    tbl[14] = mk(8'hE0, 0, 0, 8'h00, 0, 0, 0, 9'h01C, 8'd3);
    tbl[15] = mk(8'h00, 0, 0, 8'h00, 0, 0, 0, 9'h01C, 8'd3);
    tbl[16] = mk(8'h1C, 1, 0, 8'h1C, 0, 0, 1, 9'h01C, 8'd4);
    tbl[17] = mk(8'hF0, 0, 0, 8'h00, 0, 0, 1, 9'h01C, 8'd4);
    tbl[18] = mk(8'h2A, 1, 0, 8'h2A, 0, 1, 1, 9'h01C, 8'd4);
    tbl[19] = mk(8'hF0, 0, 0, 8'h00, 0, 0, 1, 9'h01C, 8'd4);
    tbl[20] = mk(8'h1C, 1, 0, 8'h1C, 0, 1, 0, 9'h01C, 8'd4);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset_vals("reset_u0", 0);
    chk_reset_vals("reset_u1", 1);

    // table: u0 drops repeats, u1 emits them with rpt=1
    for (int i = 0; i < 21; i++) begin
      step(tbl[i].b);
      e0 = tbl[i].ev && !tbl[i].rpt;
      chk($sformatf("v%0d_u0_nevt", i), cap0.size(), {31'd0, e0});
      if (e0 && cap0.size() > 0) begin
        g = cap0.pop_front();
        chk($sformatf("v%0d_u0_evt", i), {18'd0, g},
            {18'd0, tbl[i].code, tbl[i].ext, tbl[i].brk, 1'b0});
      end
      chk($sformatf("v%0d_u1_nevt", i), cap1.size(), {31'd0, tbl[i].ev});
      if (tbl[i].ev && cap1.size() > 0) begin
        g = cap1.pop_front();
        chk($sformatf("v%0d_u1_evt", i), {18'd0, g},
            {18'd0, tbl[i].code, tbl[i].ext, tbl[i].brk, tbl[i].rpt});
      end
      chk($sformatf("v%0d_u0_state", i), {14'd0, held[0], hc[0], cnt[0]},
          {14'd0, tbl[i].held, tbl[i].hc, tbl[i].cnt});
      chk($sformatf("v%0d_u1_state", i), {14'd0, held[1], hc[1], cnt[1]},
          {14'd0, tbl[i].held, tbl[i].hc, tbl[i].cnt});
      cap0.delete(); cap1.delete();
    end
    chk("pops_u0", pops[0], 32'd21);
    chk("pops_u1", pops[1], 32'd21);

    // backpressure: two bytes queued, consumer stalls 20 cycles
    evt_ready = 1'b0;
    p0 = pops[0];
    push(8'h33); push(8'h34);
    wait_valid(0, ok);
    chk("bp_valid_seen", {31'd0, ok}, 32'd1);
    snap = {ev[0], nd[0], code[0], ext[0], brk[0], rpt[0], held[0]};
    diffs = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if ({ev[0], nd[0], code[0], ext[0], brk[0], rpt[0], held[0]} !== snap) diffs++;
    end
    chk("bp_snapshot", {18'd0, snap}, {18'd0, 1'b1, 1'b1, 8'h33, 4'b0001});
    chk("bp_stable", diffs, 32'd0);
    chk("bp_one_pop", pops[0] - p0, 32'd1);
    chk("bp_fifo_held", fq0.size(), 32'd1);
    evt_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("bp_nevt", cap0.size(), 32'd2);
    if (cap0.size() == 2) begin
      chk("bp_first", {24'd0, cap0[0].code}, 32'h33);
      chk("bp_second", {24'd0, cap0[1].code}, 32'h34);
    end
    chk("bp_state", {14'd0, held[0], hc[0], cnt[0]}, {14'd0, 1'b1, 9'h034, 8'd6});
    step(8'hF0); step(8'h34);
    cap0.delete(); cap1.delete();

    // overflow: set beats clear in the same cycle, then clear alone
    rx_overflow = 1'b1; ovf_clr = 1'b1;
    @(posedge clk); #1;
    chk("ovf_set_wins", {30'd0, ovf[0], ovf[1]}, 32'd3);
    rx_overflow = 1'b0;
    @(posedge clk); #1;
    chk("ovf_clear", {30'd0, ovf[0], ovf[1]}, 32'd0);
    ovf_clr = 1'b0;

    // stale break prefix: u0 times out to a press, u1 keeps it pending
    step(8'hF0);
    repeat (12) @(posedge clk);
    #1;
    step(8'h1C);
    chk("tmo_u0_nevt", cap0.size(), 32'd1);
    if (cap0.size() > 0) chk("tmo_u0_evt", {18'd0, cap0[0]}, {18'd0, 8'h1C, 3'b000});
    chk("tmo_u1_nevt", cap1.size(), 32'd1);
    if (cap1.size() > 0) chk("tmo_u1_evt", {18'd0, cap1[0]}, {18'd0, 8'h1C, 3'b010});
    chk("tmo_cnt", {16'd0, cnt[0], cnt[1]}, {16'd0, 8'd7, 8'd6});

    // press_count wrap
    do_reset();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] c;
      c = 8'h10 + 8'(i % 192);
      push(c); push(8'hF0); push(c);
      if (i == 254 || i == 255) begin
        ok = 1'b0;
        for (int k = 0; k < 20000 && !ok; k++) begin
          @(posedge clk); #1;
          if (fq0.size() == 0 && fq1.size() == 0) ok = 1'b1;
        end
        chk($sformatf("wrap_drain%0d", i), {31'd0, ok}, 32'd1);
        repeat (8) @(posedge clk);
        #1;
        if (i == 254) begin
          chk("wrap_255", {16'd0, cnt[0], cnt[1]}, {16'd0, 8'd255, 8'd255});
          chk("wrap_nevt", cap0.size(), 32'd510);
        end else begin
          chk("wrap_0", {16'd0, cnt[0], cnt[1]}, {16'd0, 8'd0, 8'd0});
          chk("wrap_held", {30'd0, held[0], held[1]}, 32'd0);
        end
      end
    end

    // reset while an event is stalled in EMIT
    cap0.delete(); cap1.delete();
    evt_ready = 1'b0;
    push(8'h1C);
    wait_valid(0, ok);
    chk("emit_reached", {31'd0, ok}, 32'd1);
    rst = 1'b1;
    fq0.delete(); fq1.delete();
    @(posedge clk); #1;
    chk_reset_vals("rst_emit_u0", 0);
    chk_reset_vals("rst_emit_u1", 1);
    rst = 1'b0;
    evt_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    chk("pop_width", width_err, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
